// File: rtl/ramp_pwm_gen_pkg.sv
// ============================================================================
// Module   : ramp_pwm_gen_pkg
// Brief    : Shared mode encodings and default widths for the ramp PWM block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ramp_pwm_gen_pkg;

    typedef enum logic [1:0] {
        MODE_TRI    = 2'b00,
        MODE_SAW_UP = 2'b01,
        MODE_SAW_DN = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 16;
    localparam int DEF_CH      = 4;

endpackage

`default_nettype wire

// File: rtl/ramp_pwm_gen_channel.sv
// ============================================================================
// Module   : ramp_channel
// Brief    : One ramp channel: level counter, direction and wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ramp_channel
    import ramp_pwm_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  mode_e            i_mode,
    input  logic [WIDTH-1:0] i_top,
    output logic [WIDTH-1:0] o_level,
    output logic             o_dir,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_level;
    logic             r_dir;
    logic             r_wrap;
    logic [WIDTH-1:0] w_level_nxt;
    logic             w_dir_nxt;
    logic             w_wrap_nxt;

    always_comb begin
        w_level_nxt = r_level;
        w_dir_nxt   = r_dir;
        w_wrap_nxt  = 1'b0;
        if (i_tick && (i_mode != MODE_HOLD)) begin
            // A top lowered beneath the running level snaps the level down first.
            if (r_level > i_top) begin
                w_level_nxt = i_top;
                w_wrap_nxt  = 1'b1;
                w_dir_nxt   = (i_mode == MODE_SAW_UP);
            end else begin
                case (i_mode)
                    MODE_TRI: begin
                        if (r_dir) begin
                            if (r_level == i_top) begin
                                w_dir_nxt   = 1'b0;
                                w_wrap_nxt  = 1'b1;
                                w_level_nxt = (i_top != '0) ? (r_level - c_one) : '0;
                            end else begin
                                w_level_nxt = r_level + c_one;
                            end
                        end else begin
                            if (r_level == '0) begin
                                w_dir_nxt   = 1'b1;
                                w_wrap_nxt  = 1'b1;
                                w_level_nxt = (i_top != '0) ? c_one : '0;
                            end else begin
                                w_level_nxt = r_level - c_one;
                            end
                        end
                    end
                    MODE_SAW_UP: begin
                        w_dir_nxt = 1'b1;
                        if (r_level == i_top) begin
                            w_level_nxt = '0;
                            w_wrap_nxt  = 1'b1;
                        end else begin
                            w_level_nxt = r_level + c_one;
                        end
                    end
                    MODE_SAW_DN: begin
                        w_dir_nxt = 1'b0;
                        if (r_level == '0) begin
                            w_level_nxt = i_top;
                            w_wrap_nxt  = 1'b1;
                        end else begin
                            w_level_nxt = r_level - c_one;
                        end
                    end
                    default: begin
                        w_level_nxt = r_level;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_dir   <= 1'b1;
            r_wrap  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_dir   <= w_dir_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign o_level = r_level;
    assign o_dir   = r_dir;
    assign o_wrap  = r_wrap;

endmodule

`default_nettype wire

// File: rtl/ramp_pwm_gen.sv
// ============================================================================
// Module   : ramp_pwm_gen
// Brief    : Multi-channel brightness ramp generator with shared-carrier PWM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ramp_pwm_gen
    import ramp_pwm_gen_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W,
    parameter int CH      = DEF_CH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [PRESC_W-1:0]    presc,
    input  logic [CH*WIDTH-1:0]   top,
    output logic [CH*WIDTH-1:0]   level,
    output logic [CH-1:0]         dir,
    output logic [CH-1:0]         wrap,
    output logic [CH-1:0]         pwm
);

    localparam logic [PRESC_W-1:0] c_presc_one   = PRESC_W'(1);
    localparam logic [WIDTH-1:0]   c_carrier_one = WIDTH'(1);

    logic [PRESC_W-1:0]  r_presc_cnt;
    logic [WIDTH-1:0]    r_carrier;
    logic [CH-1:0]       r_pwm;
    logic                w_tick;
    logic [CH*WIDTH-1:0] w_level;

    // Equality compare: a presc lowered under the count lets it roll over.
    assign w_tick = en && (r_presc_cnt == presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_cnt <= '0;
        end else if (en) begin
            r_presc_cnt <= w_tick ? '0 : (r_presc_cnt + c_presc_one);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carrier <= '0;
            r_pwm     <= '0;
        end else begin
            r_carrier <= r_carrier + c_carrier_one;
            for (int i = 0; i < CH; i++) begin
                r_pwm[i] <= (r_carrier < w_level[i*WIDTH +: WIDTH]);
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        ramp_channel #(
            .WIDTH (WIDTH)
        ) u_ramp_channel (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_mode  (mode_e'(mode)),
            .i_top   (top[g*WIDTH +: WIDTH]),
            .o_level (w_level[g*WIDTH +: WIDTH]),
            .o_dir   (dir[g]),
            .o_wrap  (wrap[g])
        );
    end

    assign level = w_level;
    assign pwm   = r_pwm;

endmodule

`default_nettype wire

// File: tb/tb_ramp_pwm_gen.sv
// ============================================================================
// Module   : tb_ramp_pwm_gen
// Brief    : Directed, table-driven self-checking bench for ramp_pwm_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ramp_pwm_gen;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 16;
    localparam int CH      = 2;
    localparam int NVEC    = 20;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [1:0]          mode;
    logic [PRESC_W-1:0]  presc;
    logic [CH*WIDTH-1:0] top;
    logic [CH*WIDTH-1:0] level;
    logic [CH-1:0]       dir;
    logic [CH-1:0]       wrap;
    logic [CH-1:0]       pwm;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r;
        logic [1:0] m;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] l0;
        logic [7:0] l1;
        logic [1:0] d;
        logic [1:0] w;
    } vec_t;

    vec_t vec [NVEC];

    always #5 clk = ~clk;

    ramp_pwm_gen #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W),
        .CH      (CH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .presc (presc),
        .top   (top),
        .level (level),
        .dir   (dir),
        .wrap  (wrap),
        .pwm   (pwm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic count_pwm0(output int hi, output int wr);
        hi = 0;
        wr = 0;
        repeat (256) begin
            step();
            hi += int'(pwm[0]);
            wr += int'(wrap[0]);
        end
    endtask

    initial begin
        int hi;
        int wr;
        int exp_l;
        logic exp_w;

        // r, mode, top0, top1, level0, level1, dir{1,0}, wrap{1,0}
        vec[0]  = '{1'b1, 2'd0, 8'd3, 8'd2, 8'd0, 8'd0, 2'b11, 2'b00};
        vec[1]  = '{1'b0, 2'd0, 8'd3, 8'd2, 8'd1, 8'd1, 2'b11, 2'b00};
        vec[2]  = '{1'b0, 2'd0, 8'd3, 8'd2, 8'd2, 8'd2, 2'b11, 2'b00};
        vec[3]  = '{1'b0, 2'd0, 8'd3, 8'd2, 8'd3, 8'd1, 2'b01, 2'b10};
        vec[4]  = '{1'b0, 2'd0, 8'd3, 8'd2, 8'd2, 8'd0, 2'b00, 2'b01};
        vec[5]  = '{1'b0, 2'd0, 8'd3, 8'd2, 8'd1, 8'd1, 2'b10, 2'b10};
        vec[6]  = '{1'b0, 2'd0, 8'd3, 8'd2, 8'd0, 8'd2, 2'b10, 2'b00};
        vec[7]  = '{1'b0, 2'd0, 8'd3, 8'd2, 8'd1, 8'd1, 2'b01, 2'b11};
        vec[8]  = '{1'b1, 2'd2, 8'd0, 8'd4, 8'd0, 8'd0, 2'b11, 2'b00};
        vec[9]  = '{1'b0, 2'd2, 8'd0, 8'd4, 8'd0, 8'd4, 2'b00, 2'b11};
        vec[10] = '{1'b0, 2'd2, 8'd0, 8'd4, 8'd0, 8'd3, 2'b00, 2'b01};
        vec[11] = '{1'b0, 2'd2, 8'd0, 8'd4, 8'd0, 8'd2, 2'b00, 2'b01};
        vec[12] = '{1'b0, 2'd2, 8'd0, 8'd4, 8'd0, 8'd1, 2'b00, 2'b01};
        vec[13] = '{1'b0, 2'd2, 8'd0, 8'd4, 8'd0, 8'd0, 2'b00, 2'b01};
        vec[14] = '{1'b0, 2'd2, 8'd0, 8'd4, 8'd0, 8'd4, 2'b00, 2'b11};
        vec[15] = '{1'b0, 2'd1, 8'd0, 8'd4, 8'd0, 8'd0, 2'b11, 2'b11};
        vec[16] = '{1'b0, 2'd1, 8'd0, 8'd4, 8'd0, 8'd1, 2'b11, 2'b01};
        vec[17] = '{1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b11};
        vec[18] = '{1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'b11, 2'b11};
        vec[19] = '{1'b0, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 2'b11, 2'b00};

        rst   = 1'b1;
        en    = 1'b1;
        mode  = 2'd0;
        presc = '0;
        top   = '0;
        @(negedge clk);

        // Table: presc = 0, so every non-reset row is one tick.
        for (int i = 0; i < NVEC; i++) begin
            rst  = vec[i].r;
            mode = vec[i].m;
            top  = {vec[i].t1, vec[i].t0};
            step();
            chk($sformatf("vec%0d level0", i), 32'(level[7:0]),  32'(vec[i].l0));
            chk($sformatf("vec%0d level1", i), 32'(level[15:8]), 32'(vec[i].l1));
            chk($sformatf("vec%0d dir", i),    32'(dir),         32'(vec[i].d));
            chk($sformatf("vec%0d wrap", i),   32'(wrap),        32'(vec[i].w));
            if (vec[i].r) chk($sformatf("vec%0d pwm", i), 32'(pwm), 32'd0);
        end

        // Saw up with presc = 2: one step every third clock, wrap at 5 -> 0.
        rst = 1'b1;
        step();
        rst   = 1'b0;
        presc = 16'd2;
        mode  = 2'd1;
        top   = {8'd5, 8'd5};
        for (int n = 1; n <= 21; n++) begin
            step();
            exp_l = (n / 3) % 6;
            exp_w = (n % 3 == 0) && (exp_l == 0);
            chk($sformatf("saw_up clk%0d level0", n), 32'(level[7:0]), 32'(exp_l));
            chk($sformatf("saw_up clk%0d wrap0", n),  32'(wrap[0]),    32'(exp_w));
        end

        // Freeze a triangle at level 2 while the carrier keeps running.
        rst = 1'b1;
        step();
        rst   = 1'b0;
        presc = '0;
        mode  = 2'd0;
        top   = {8'd3, 8'd3};
        step();
        step();
        chk("pre_freeze level0", 32'(level[7:0]), 32'd2);
        en = 1'b0;
        count_pwm0(hi, wr);
        chk("freeze level0",   32'(level[7:0]), 32'd2);
        chk("freeze dir0",     32'(dir[0]),     32'd1);
        chk("freeze pwm0 hi",  32'(hi),         32'd2);
        chk("freeze wrap0",    32'(wr),         32'd0);
        en = 1'b1;
        step();
        chk("resume level0",   32'(level[7:0]), 32'd3);

        // Hold at level 64: duty must be exactly 64 of 256 clocks.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        mode = 2'd0;
        top  = {8'd200, 8'd200};
        repeat (64) step();
        chk("ramp to 64 level0", 32'(level[7:0]), 32'd64);
        mode = 2'd3;
        count_pwm0(hi, wr);
        chk("hold64 pwm0 hi",  32'(hi),         32'd64);
        chk("hold64 level0",   32'(level[7:0]), 32'd64);
        chk("hold64 wrap0",    32'(wr),         32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_pwm0(hi, wr);
        chk("hold0 pwm0 hi",   32'(hi),         32'd0);

        // Top lowered under the running level, then reset mid-ramp.
        mode = 2'd0;
        top  = {8'd255, 8'd255};
        repeat (200) step();
        chk("ramp to 200 level0", 32'(level[7:0]), 32'd200);
        chk("ramp to 200 dir0",   32'(dir[0]),     32'd1);
        top = {8'd255, 8'd100};
        step();
        chk("clamp level0", 32'(level[7:0]), 32'd100);
        chk("clamp wrap0",  32'(wrap[0]),    32'd1);
        chk("clamp dir0",   32'(dir[0]),     32'd0);
        chk("clamp level1", 32'(level[15:8]), 32'd201);
        step();
        chk("post clamp level0", 32'(level[7:0]), 32'd99);
        chk("post clamp wrap0",  32'(wrap[0]),    32'd0);
        rst = 1'b1;
        step();
        chk("midrst level", 32'(level), 32'd0);
        chk("midrst dir",   32'(dir),   32'd3);
        chk("midrst wrap",  32'(wrap),  32'd0);
        chk("midrst pwm",   32'(pwm),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ramp_pwm_gen.md
Name: ramp_pwm_gen

Overview:
Multi-channel brightness ramp generator for the low/high light path. Each channel runs a level counter that steps once per prescaler tick. The counter follows a triangle, sawtooth-up or sawtooth-down profile between 0 and a per-channel top value, or holds its value. Each channel's level drives a PWM output compared against a shared free-running carrier, so LEDs fade up and down without software involvement.

Parameters:
WIDTH, 8, bit width of level, top and PWM carrier
PRESC_W, 16, bit width of prescaler compare value
CH, 4, number of independent ramp/PWM channels

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
en  input  1  1 = ramps advance; 0 = prescaler and levels frozen
mode  input  2  00 triangle, 01 saw up, 10 saw down, 11 hold (shared by all channels)
presc  input  PRESC_W  a level step occurs every presc+1 clocks
top  input  CH*WIDTH  per-channel peak value; channel i uses bits [i*WIDTH +: WIDTH]
level  output  CH*WIDTH  registered per-channel ramp value, same packing as top
dir  output  CH  per-channel direction (1 = up), registered
wrap  output  CH  one-cycle pulse on the cycle a channel reverses or wraps
pwm  output  CH  registered PWM output per channel

Behaviour:
- Reset:
  - level = 0, dir = all 1, wrap = 0, pwm = 0.
  - Prescaler count = 0, carrier = 0.
- Prescaler:
  - While en = 1: if presc_cnt == presc then presc_cnt <= 0 and tick = 1; else presc_cnt + 1.
  - presc = 0 gives a tick every clock.
  - The compare is equality. If presc changes to a value below presc_cnt, the count runs to 2^PRESC_W-1, wraps to 0 and continues.
- en = 0: presc_cnt, level and dir hold; wrap = 0; carrier and pwm keep running.
- Per-channel update happens only on tick; level changes on the clock edge of the tick.
- Clamp rule, applied before mode logic, in all modes except hold: if level > top, then level <= top, wrap = 1, dir <= 0 (triangle/saw down) or dir <= 1 (saw up).
- Triangle:
  - Up: if level == top, dir <= 0 and wrap = 1; level <= level-1 if top > 0, else stays 0. Otherwise level + 1.
  - Down: if level == 0, dir <= 1 and wrap = 1; level <= 1 if top > 0. Otherwise level - 1.
  - Period is 2*top ticks.
- Saw up: level == top -> level <= 0, wrap = 1; otherwise level + 1. dir forced to 1.
- Saw down: level == 0 -> level <= top, wrap = 1; otherwise level - 1. dir forced to 0.
- Hold: level and dir unchanged, wrap = 0, clamp not applied.
- top = 0 in any ramp mode: level stays 0, wrap pulses every tick.
- Mode change: takes effect on the next tick and continues from the current level; no reset of level.
- All arithmetic is WIDTH bits, with no wrap-around past 0 or top (guaranteed by the compares above).
- Carrier:
  - WIDTH-bit counter, increments every clock regardless of en, wraps 2^WIDTH-1 -> 0.
  - pwm[i] <= (carrier < level_i), one cycle of register latency.
  - level 0 gives pwm constantly 0; level L gives L high cycles per 2^WIDTH-cycle period.
- Reset asserted mid-operation: all state returns to reset values on that edge, overriding tick and en.
- No latches: dir is a register updated only in the clocked process.

Decomposition:
- Shared package:
  - mode encodings MODE_TRI = 2'b00, MODE_SAW_UP = 2'b01, MODE_SAW_DN = 2'b10, MODE_HOLD = 2'b11.
  - Default WIDTH/PRESC_W constants.
- Sub-module ramp_channel (level, dir, wrap and clamp logic for one channel, inputs tick/mode/top), instantiated CH times in a generate loop.
- Prescaler, carrier and PWM compare live in the top level.

Test Plan:
1. WIDTH=8, CH=2, mode=00, presc=0, top0=3, en=1 after reset -> level0 per clock 1,2,3,2,1,0,1; wrap0 high on the steps to 2 (after 3) and to 1 (after 0); dir0 toggles at those steps.
2. presc=2, mode=01, top0=5 -> level0 holds 3 clocks per value: 0..5 then 0 with one wrap pulse; tick spacing exactly 3 clocks.
3. mode=10, top1=4, from reset -> first tick gives level1=4 with wrap; then 3,2,1,0,4.
4. Triangle running at level0=2, drop en for 10 clocks -> level0 and dir0 frozen, pwm0 still high 2 of every 256 clocks; raising en resumes at the next prescaler match.
5. mode=11 with level0=64 -> pwm0 high exactly 64 of 256 clocks each carrier period; with level 0, pwm0 never high.
6. Triangle at level0=200, set top0=100 -> next tick level0=100, wrap0=1, dir0=0; assert rst mid-ramp -> next edge all levels 0, dir all 1, pwm 0.
